// File: rtl/priority_event_fifo.sv
// Change detector for the priority encoder's code: each new code is timestamped
// with a free-running counter and queued in a show-ahead FIFO for the host to drain.
module priority_event_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               code_in,
    input  logic                     sample_en,
    input  logic                     rd_pop,
    output logic                     rd_valid,
    output logic [TS_W+7:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = TS_W + 8;
    localparam logic [7:0] IDLE_CODE = 8'hF0;

    logic [7:0]        prev_code_reg;
    logic [TS_W-1:0]   ts_reg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              overflow_reg;

    logic change;
    logic pop_ok;
    logic full;
    logic wr_ok;
    logic drop;

    assign change = sample_en && (code_in != prev_code_reg);
    assign pop_ok = rd_pop && rd_valid;
    assign full   = (count_reg == CNT_W'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_ok  = change && (!full || pop_ok);
    assign drop   = change && full && !pop_ok;

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_code_reg <= IDLE_CODE;
            ts_reg        <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            ts_reg    <= ts_reg + TS_W'(1);
            count_reg <= count_next;
            if (change)
                prev_code_reg <= code_in;
            if (wr_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            // A drop on the same edge as a clear leaves the flag set.
            if (drop)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= {ts_reg, code_in};
    end

    assign rd_valid = (count_reg != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_priority_event_fifo.sv
// Randomised and directed checks of priority_event_fifo against a queue-based reference model.
module tb_priority_event_fifo;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  code_in = 8'hF0;
    logic        sample_en = 1'b0;
    logic        rd_pop = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  count;
    logic        overflow;

    priority_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .sample_en (sample_en),
        .rd_pop    (rd_pop),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO is a plain queue of {timestamp, code}.
    logic [15:0] q[$];
    logic [7:0]  ts_m;
    logic [7:0]  prev_m;
    logic        ovf_m;

    wire [20:0] act_state = {rd_valid, count, overflow, rd_data};

    function automatic logic [20:0] exp_state();
        logic [15:0] head;
        head = (q.size() > 0) ? q[0] : 16'h0000;
        return {q.size() > 0, 3'(q.size()), ovf_m, head};
    endfunction

    task automatic model_reset();
        q.delete();
        ts_m   = 8'h00;
        prev_m = 8'hF0;
        ovf_m  = 1'b0;
    endtask

    task automatic cycle(input logic [7:0] c, input logic se, input logic pp, input logic cl);
        logic ch, pv, full0;
        code_in = c; sample_en = se; rd_pop = pp; clr_ovf = cl;
        @(posedge clk);
        ch    = se && (c != prev_m);
        pv    = pp && (q.size() > 0);
        full0 = (q.size() == DEPTH);
        if (pv) void'(q.pop_front());
        if (ch && full0 && !pv) ovf_m = 1'b1;
        else begin
            if (ch) q.push_back({ts_m, c});
            if (cl) ovf_m = 1'b0;
        end
        if (ch) prev_m = c;
        ts_m = ts_m + 8'h01;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        code_in = 8'hF0; sample_en = 1'b0; rd_pop = 1'b0; clr_ovf = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        if (act_state !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_state actual=%h required=%h", act_state, 21'h0);
        end
        n_checks++;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(8'hF0, 1'b1, 1'b0, 1'b0);
            if (act_state !== exp_state()) begin
                n_fail++;
                $display("FAIL idle_cyc%0d actual=%h required=%h", i, act_state, exp_state());
            end
            n_checks++;
        end
        cycle(8'h05, 1'b1, 1'b0, 1'b0);
        if (rd_data !== 16'h0A05 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL ts_after_idle actual=%h/%0d required=0a05/1", rd_data, count);
        end
        n_checks++;
        $display("test_reset done");
    endtask

    task automatic test_single_event();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(8'hF0, 1'b1, 1'b0, 1'b0);
        cycle(8'h0F, 1'b1, 1'b0, 1'b0);
        if ({rd_valid, rd_data, count} !== {1'b1, 16'h050F, 3'd1}) begin
            n_fail++;
            $display("FAIL single_event actual=%b/%h/%0d required=1/050f/1", rd_valid, rd_data, count);
        end
        n_checks++;
        cycle(8'h0F, 1'b1, 1'b1, 1'b0);
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL single_pop actual=%b/%h required=0/0000", rd_valid, rd_data);
        end
        n_checks++;
        $display("test_single_event done");
    endtask

    task automatic test_sequence();
        logic [7:0]  codes [4];
        logic [15:0] expd  [3];
        codes = '{8'h03, 8'h03, 8'h0A, 8'hF0};
        expd  = '{16'h1403, 16'h160A, 16'h17F0};
        do_reset();
        for (int i = 0; i < 20; i++) cycle(8'hF0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(codes[i], 1'b1, 1'b0, 1'b0);
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL seq_count actual=%0d required=3", count);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            if (rd_data !== expd[i]) begin
                n_fail++;
                $display("FAIL seq_entry%0d actual=%h required=%h", i, rd_data, expd[i]);
            end
            n_checks++;
            cycle(8'hF0, 1'b1, 1'b1, 1'b0);
        end
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_empty actual=%b required=0", rd_valid);
        end
        n_checks++;
        $display("test_sequence done");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(8'(i), 1'b1, 1'b0, 1'b0);
        if ({count, overflow, rd_data} !== {3'd4, 1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL ovf_fill actual=%0d/%b/%h required=4/1/0001", count, overflow, rd_data);
        end
        n_checks++;
        cycle(8'h05, 1'b1, 1'b0, 1'b1);
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear actual=%b required=0", overflow);
        end
        n_checks++;
        cycle(8'h06, 1'b1, 1'b1, 1'b0);
        if ({count, overflow, rd_data} !== {3'd4, 1'b0, 16'h0102}) begin
            n_fail++;
            $display("FAIL ovf_push_pop_full actual=%0d/%b/%h required=4/0/0102", count, overflow, rd_data);
        end
        n_checks++;
        cycle(8'h07, 1'b1, 1'b0, 1'b1);
        if (overflow !== 1'b1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set_wins actual=%b/%0d required=1/4", overflow, count);
        end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            cycle(8'h07, 1'b1, 1'b1, 1'b0);
            if (act_state !== exp_state()) begin
                n_fail++;
                $display("FAIL ovf_drain%0d actual=%h required=%h", i, act_state, exp_state());
            end
            n_checks++;
        end
        $display("test_overflow done");
    endtask

    task automatic test_gating_wrap();
        do_reset();
        for (int i = 0; i < 257; i++) begin
            cycle((i % 2 == 0) ? 8'h01 : 8'h02, 1'b0, 1'b0, 1'b0);
            if (count !== 3'd0 || rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gated_cyc%0d actual=%0d/%b required=0/0", i, count, rd_valid);
            end
            n_checks++;
        end
        cycle(8'h02, 1'b1, 1'b0, 1'b0);
        if (rd_data !== 16'h0102) begin
            n_fail++;
            $display("FAIL wrap_ts actual=%h required=0102", rd_data);
        end
        n_checks++;
        $display("test_gating_wrap done");
    endtask

    task automatic test_random();
        logic [7:0] pool [5];
        pool = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'h3C};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(pool[$urandom_range(0, 4)], ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
            if (act_state !== exp_state()) begin
                n_fail++;
                $display("FAIL random_cyc%0d actual=%h required=%h", i, act_state, exp_state());
            end
            n_checks++;
        end
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(8'(i), 1'b1, 1'b0, 1'b0);
        cycle(8'h05, 1'b1, 1'b1, 1'b0);
        if (act_state !== exp_state() || count !== 3'd3 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup actual=%h required=%h", act_state, exp_state());
        end
        n_checks++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        if (act_state !== 21'h0) begin
            n_fail++;
            $display("FAIL async_reset actual=%h required=%h", act_state, 21'h0);
        end
        n_checks++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(8'hF0, 1'b1, 1'b0, 1'b0);
        if (act_state !== exp_state()) begin
            n_fail++;
            $display("FAIL async_after actual=%h required=%h", act_state, exp_state());
        end
        n_checks++;
        $display("test_async_reset done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_event();
        test_sequence();
        test_overflow();
        test_gating_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
